// File: rtl/tp_sound_cmd_tx.sv
// Sound command transmitter: queues main-CPU command bytes and replays them
// to the sound board as latch strobe, IRQ pulse and a hold-off gap.
module tp_sound_cmd_tx #(
  parameter int DEPTH     = 4,
  parameter int IRQ_WIDTH = 4,
  parameter int HOLDOFF   = 3072
) (
  input  logic       clk_49m,
  input  logic       reset,
  input  logic       cen_3m,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [7:0] sound_data,
  output logic       cs_sounddata,
  output logic       irq_trigger,
  output logic       busy,
  output logic [4:0] fifo_level
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  LVL_MAX   = 5'(DEPTH);
  localparam logic [15:0] IRQ_LAST  = 16'(IRQ_WIDTH - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    IRQ,
    HOLD
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   cnt;
  logic          push;
  logic          pop;
  logic [4:0]    level_nxt;

  assign push = cmd_valid & cmd_ready;
  assign pop  = cen_3m & (state == IDLE) & (fifo_level != 5'd0);

  always_comb begin
    level_nxt = fifo_level;
    if (push & ~pop)
      level_nxt = fifo_level + 5'd1;
    else if (pop & ~push)
      level_nxt = fifo_level - 5'd1;
  end

  always_ff @(posedge clk_49m) begin
    if (push)
      mem[wr_ptr] <= cmd_data;
  end

  // Ready follows the registered level, so a full FIFO never accepts
  // even while a pop is in flight.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      fifo_level <= 5'd0;
      cmd_ready  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      fifo_level <= level_nxt;
      cmd_ready  <= (level_nxt < LVL_MAX);
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      cnt          <= 16'd0;
      sound_data   <= 8'h00;
      cs_sounddata <= 1'b0;
      irq_trigger  <= 1'b0;
      busy         <= 1'b0;
    end else if (cen_3m) begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            sound_data   <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + AW'(1);
            cs_sounddata <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          cs_sounddata <= 1'b0;
          irq_trigger  <= 1'b1;
          cnt          <= 16'd0;
          state        <= IRQ;
        end
        IRQ: begin
          if (cnt == IRQ_LAST) begin
            irq_trigger <= 1'b0;
            cnt         <= 16'd0;
            state       <= HOLD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            busy  <= 1'b0;
            cnt   <= 16'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tp_sound_cmd_tx.sv
// Directed bench for tp_sound_cmd_tx with a short hold-off so that
// multi-command sequences stay within a small cycle budget.
module tb_tp_sound_cmd_tx;

  localparam int DEPTH = 4;
  localparam int IW    = 4;
  localparam int HO    = 20;
  localparam int T_CS  = 16;
  localparam int T_IRQ = IW * 16;
  localparam int T_BSY = (1 + IW + HO) * 16;
  localparam int T_GAP = (1 + IW + HO + 1) * 16;

  logic       clk_49m;
  logic       reset;
  logic       cen_3m;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [7:0] sound_data;
  logic       cs_sounddata;
  logic       irq_trigger;
  logic       busy;
  logic [4:0] fifo_level;

  tp_sound_cmd_tx #(
    .DEPTH(DEPTH),
    .IRQ_WIDTH(IW),
    .HOLDOFF(HO)
  ) dut (
    .clk_49m(clk_49m),
    .reset(reset),
    .cen_3m(cen_3m),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .sound_data(sound_data),
    .cs_sounddata(cs_sounddata),
    .irq_trigger(irq_trigger),
    .busy(busy),
    .fifo_level(fifo_level)
  );

  int n_chk = 0;
  int n_ok  = 0;

  logic cen_en;
  int   phase;

  logic [7:0] obs[$];
  int   cyc = 0;
  int   last_rise = -1;
  int   min_gap = 1000000;
  int   cs_run = 0, cs_len = 0;
  int   irq_run = 0, irq_len = 0;
  int   bsy_run = 0, bsy_len = 0;
  int   stab_err = 0;
  int   max_lvl = 0;
  logic [7:0] cur = 8'h00;
  logic cs_q = 1'b0, irq_q = 1'b0, bsy_q = 1'b0;

  initial begin
    clk_49m = 1'b0;
    forever #5 clk_49m = ~clk_49m;
  end

  // Enable generator; the phase freezes with cen_en so a pause stretches time exactly.
  initial begin
    cen_3m = 1'b0;
    phase  = 0;
    forever begin
      @(negedge clk_49m);
      if (cen_en) begin
        phase  = (phase + 1) % 16;
        cen_3m = (phase == 15);
      end else begin
        cen_3m = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_49m);
      #1;
      if (cs_sounddata && !cs_q) begin
        obs.push_back(sound_data);
        cur = sound_data;
        if (last_rise >= 0 && (cyc - last_rise) < min_gap)
          min_gap = cyc - last_rise;
        last_rise = cyc;
      end else if (busy && sound_data != cur) begin
        stab_err++;
      end
      if (cs_sounddata) cs_run++;
      else if (cs_q) begin cs_len = cs_run; cs_run = 0; end
      if (irq_trigger) irq_run++;
      else if (irq_q) begin irq_len = irq_run; irq_run = 0; end
      if (busy) bsy_run++;
      else if (bsy_q) begin bsy_len = bsy_run; bsy_run = 0; end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      cs_q  = cs_sounddata;
      irq_q = irq_trigger;
      bsy_q = busy;
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    logic rdy;
    int n;
    n = 0;
    @(negedge clk_49m);
    cmd_valid = 1'b1;
    cmd_data  = b;
    forever begin
      rdy = cmd_ready;
      @(posedge clk_49m);
      n++;
      if (rdy || n >= 5000) break;
      @(negedge clk_49m);
    end
    if (!rdy) chk("push_tmo", 32'(rdy), 32'd1);
  endtask

  task automatic endv();
    @(negedge clk_49m);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_49m);
      n++;
    end while (!(busy == 1'b0 && fifo_level == 5'd0) && n < budget);
    chk("idle_tmo", 32'(busy == 1'b0 && fifo_level == 5'd0), 32'd1);
  endtask

  task automatic wait_irq(input logic v, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_49m);
      n++;
    end while (irq_trigger != v && n < budget);
    chk("irq_tmo", 32'(irq_trigger), 32'(v));
  endtask

  task automatic wait_bsy(input logic v, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_49m);
      n++;
    end while (busy != v && n < budget);
    chk("bsy_tmo", 32'(busy), 32'(v));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_lvl"}, 32'(fifo_level), 32'd0);
    chk({tag, "_bsy"}, 32'(busy), 32'd0);
    chk({tag, "_cs"}, 32'(cs_sounddata), 32'd0);
    chk({tag, "_irq"}, 32'(irq_trigger), 32'd0);
    chk({tag, "_sd"}, 32'(sound_data), 32'h00);
  endtask

  initial begin
    logic [7:0] exp_b;
    reset     = 1'b0;
    cen_en    = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;

    repeat (5) @(negedge clk_49m);
    chk_rst("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk_49m);

    // single command
    obs.delete();
    push(8'h5A);
    endv();
    chk("one_lvl", 32'(fifo_level), 32'd1);
    wait_idle(2000);
    chk("one_n", 32'(obs.size()), 32'd1);
    chk("one_byte", 32'(obs[0]), 32'h5A);
    chk("one_cs", 32'(cs_len), 32'(T_CS));
    chk("one_irq", 32'(irq_len), 32'(T_IRQ));
    chk("one_bsy", 32'(bsy_len), 32'(T_BSY));
    chk("one_stab", 32'(stab_err), 32'd0);

    // fill with the FSM frozen, then release
    obs.delete();
    last_rise = -1;
    min_gap   = 1000000;
    cen_en    = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    @(negedge clk_49m);
    chk("fill_lvl", 32'(fifo_level), 32'd4);
    chk("fill_rdy", 32'(cmd_ready), 32'd0);
    fork
      push(8'h05);
      begin
        repeat (20) @(negedge clk_49m);
        chk("blk_lvl", 32'(fifo_level), 32'd4);
        chk("blk_rdy", 32'(cmd_ready), 32'd0);
        cen_en = 1'b1;
      end
    join
    endv();
    wait_idle(5 * T_GAP + 1000);
    chk("fill_n", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("fill_ord", 32'(obs[i]), 32'(i + 1));
    chk("fill_gap", 32'(min_gap), 32'(T_GAP));

    // streaming with pointer wrap
    obs.delete();
    max_lvl   = 0;
    last_rise = -1;
    min_gap   = 1000000;
    for (int i = 0; i < 20; i++) push(8'(i * 13 + 7));
    endv();
    wait_idle(20 * T_GAP + 1000);
    chk("wrap_n", 32'(obs.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      exp_b = 8'(i * 13 + 7);
      chk("wrap_ord", 32'(obs[i]), 32'(exp_b));
    end
    chk("wrap_max", 32'(max_lvl), 32'd4);
    chk("wrap_gap", 32'(min_gap), 32'(T_GAP));
    chk("wrap_stab", 32'(stab_err), 32'd0);

    // push and pop on the same edge at level 2
    obs.delete();
    cen_en = 1'b0;
    push(8'hA1);
    push(8'hB2);
    endv();
    chk("sim_lvl0", 32'(fifo_level), 32'd2);
    cen_en = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk_49m);
      #1;
      if (cen_3m) break;
    end
    chk("sim_cen", 32'(cen_3m), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = 8'hC3;
    @(posedge clk_49m);
    #1;
    chk("sim_lvl", 32'(fifo_level), 32'd2);
    chk("sim_head", 32'(sound_data), 32'hA1);
    chk("sim_cs", 32'(cs_sounddata), 32'd1);
    endv();
    wait_idle(3 * T_GAP + 1000);
    chk("sim_n", 32'(obs.size()), 32'd3);
    chk("sim_o0", 32'(obs[0]), 32'hA1);
    chk("sim_o1", 32'(obs[1]), 32'hB2);
    chk("sim_o2", 32'(obs[2]), 32'hC3);

    // enable paused for 1000 clocks during the hold-off
    obs.delete();
    push(8'h5C);
    endv();
    wait_irq(1'b1, 500);
    wait_irq(1'b0, 500);
    repeat (3) @(negedge clk_49m);
    #2;
    cen_en = 1'b0;
    fork
      begin
        repeat (1000) @(negedge clk_49m);
        #2;
        cen_en = 1'b1;
      end
      begin
        push(8'h6D);
        endv();
        repeat (5) @(negedge clk_49m);
        chk("frz_lvl", 32'(fifo_level), 32'd1);
        chk("frz_bsy", 32'(busy), 32'd1);
        chk("frz_sd", 32'(sound_data), 32'h5C);
      end
    join
    wait_bsy(1'b0, 2000);
    chk("frz_len", 32'(bsy_len), 32'(T_BSY + 1000));
    wait_idle(2 * T_GAP + 500);
    chk("frz_n", 32'(obs.size()), 32'd2);
    chk("frz_o1", 32'(obs[1]), 32'h6D);

    // reset during IRQ with three commands queued
    obs.delete();
    push(8'h11);
    endv();
    wait_irq(1'b1, 500);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    endv();
    chk("mid_lvl", 32'(fifo_level), 32'd3);
    chk("mid_irq", 32'(irq_trigger), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_rst("mid");
    @(negedge clk_49m);
    reset = 1'b1;
    repeat (2000) @(negedge clk_49m);
    chk("post_n", 32'(obs.size()), 32'd1);
    chk("post_bsy", 32'(busy), 32'd0);
    chk("post_lvl", 32'(fifo_level), 32'd0);
    push(8'h77);
    endv();
    chk("re_lvl", 32'(fifo_level), 32'd1);
    wait_idle(T_GAP + 500);
    chk("re_n", 32'(obs.size()), 32'd2);
    chk("re_byte", 32'(obs[1]), 32'h77);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/tp_sound_cmd_tx.md
TP_SOUND_CMD_TX -- requirements
Module: tp_sound_cmd_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO depth in entries; power of two, 2..16.
REQ-002 SHALL have parameter IRQ_WIDTH, default 4: irq_trigger high time in cen_3m ticks; range 1..255.
REQ-003 SHALL have parameter HOLDOFF, default 3072: minimum gap in cen_3m ticks after the IRQ pulse before the next command; range 1..65535.
REQ-004 SHALL have port clk_49m  input  1  single system clock, 49.152 MHz; all logic on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port cen_3m  input  1  clock enable, one clk_49m cycle in every 16.
REQ-007 SHALL have port cmd_valid  input  1  main CPU offers a sound command.
REQ-008 SHALL have port cmd_data  input  8  sound command byte.
REQ-009 SHALL have port cmd_ready  output  1  FIFO can accept; a push occurs when cmd_valid & cmd_ready on any clk_49m edge.
REQ-010 SHALL have port sound_data  output  8  byte presented to the sound board latch.
REQ-011 SHALL have port cs_sounddata  output  1  latch strobe to the sound board.
REQ-012 SHALL have port irq_trigger  output  1  sound CPU interrupt request.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-014 SHALL have port fifo_level  output  5  current FIFO occupancy, 0..DEPTH.

Function
REQ-015 cmd_ready SHALL equal (fifo_level < DEPTH), registered; it SHALL be low when full, even if a pop occurs in the same cycle.
REQ-016 FIFO SHALL be first-in first-out; read and write pointers SHALL wrap modulo DEPTH; a push when full SHALL be impossible by construction, and the FIFO SHALL never drop or duplicate a byte.
REQ-017 FSM states SHALL be IDLE, LOAD, IRQ and HOLD; every state transition SHALL occur only on clk_49m edges where cen_3m = 1.
REQ-018 IDLE: on a cen_3m tick with fifo_level > 0 (value registered before that edge), the FSM SHALL pop the head into sound_data and go to LOAD.
REQ-019 A byte pushed on the same edge as an IDLE cen_3m tick with the FIFO empty SHALL NOT be popped until the next cen_3m tick.
REQ-020 LOAD: cs_sounddata SHALL be 1 for exactly one cen_3m period (16 clk_49m cycles); the next cen_3m tick SHALL move the FSM to IRQ.
REQ-021 IRQ: irq_trigger SHALL be 1 for exactly IRQ_WIDTH cen_3m periods, then the FSM SHALL move to HOLD; sound_data SHALL stay stable from LOAD entry through the end of HOLD.
REQ-022 HOLD: a 16-bit counter SHALL count HOLDOFF cen_3m ticks, then the FSM SHALL return to IDLE; cs_sounddata and irq_trigger SHALL be 0 in HOLD and IDLE.
REQ-023 Back-to-back commands: minimum spacing between successive cs_sounddata rising edges SHALL be (1 + IRQ_WIDTH + HOLDOFF + 1) cen_3m periods.
REQ-024 Pushes SHALL be accepted in every FSM state.
REQ-025 fifo_level SHALL update on the edge after a push or pop; a simultaneous push and pop SHALL leave it unchanged.
REQ-026 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-027 If cen_3m is held low, the FSM and counters SHALL freeze while FIFO pushes continue.

Reset
REQ-028 reset = 0 SHALL asynchronously force: FSM = IDLE; pointers, counters and fifo_level = 0; sound_data = 8'h00; cs_sounddata = 0; irq_trigger = 0; busy = 0; cmd_ready = 1.
REQ-029 Reset asserted mid-operation (any state) SHALL discard all queued and in-flight commands, with no residual strobe or IRQ.
REQ-030 After reset release, the first pop SHALL occur no earlier than the first cen_3m tick following a push.

Verification
REQ-031 Single command: push 8'h5A in IDLE -> on the next cen_3m tick, sound_data = 8'h5A and cs_sounddata is high for 16 clocks; irq_trigger is then high for 64 clocks; busy is high for (1 + 4 + 3072) × 16 clocks.
REQ-032 Fill: push 8'h01..8'h05 back-to-back with DEPTH = 4 -> cmd_ready falls after the 4th accepted push (5th blocked until the first pop); all bytes emerge in order 01,02,03,04,05.
REQ-033 Pointer wrap: stream 20 commands with cmd_valid held high -> output order matches input order exactly and fifo_level never exceeds 4.
REQ-034 Simultaneous push and pop at fifo_level = 2 -> fifo_level stays 2 and the popped byte is the oldest entry.
REQ-035 Reset in IRQ state with 3 queued commands -> irq_trigger drops immediately, fifo_level = 0, and no further cs_sounddata occurs without new pushes.
REQ-036 cen_3m held low for 1000 clocks during HOLD -> the remaining hold count is unchanged when cen_3m resumes.
